card_dealer: RTL and testbench

Card source for the bell-game datapath. It flips one pseudo-random card at a time, alternating between player 1 and player 2, at a fixed cadence, and presents both face-up cards (colour and number) to the bell judge and score logic. It freezes the table when the bell is hit and clears the pile once the round is resolved. It also reports the number of cards on the table, which is the point value awarded for a correct bell.

---
 rtl/card_dealer.sv | 145 ++++++++++++++
 tb/tb_card_dealer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card source for the bell game: deals LFSR-drawn cards alternately to two players
// at a fixed cadence, freezes on a bell hit and clears the pile once scoring is done.
module card_dealer #(
    parameter int          DEAL_PERIOD = 1000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       bell_hit,
    input  logic       bell_done,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic       card_valid,
    output logic       deal_pulse,
    output logic [7:0] count
);

    typedef enum logic [2:0] {S_IDLE, S_DEAL, S_WAIT, S_HOLD, S_CLEAR} state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]  SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int           TW         = $clog2(DEAL_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DEAL_PERIOD - 2);

    state_t        r_state;
    state_t        w_stateNext;
    logic [15:0]   r_lfsr;
    logic [15:0]   w_lfsrNext;
    logic [2:0]    w_num;
    logic [TW-1:0] r_timer;
    logic          r_turn;
    logic [1:0]    r_c1;
    logic [1:0]    r_c2;
    logic [2:0]    r_n1;
    logic [2:0]    r_n2;
    logic          r_cardValid;
    logic          r_dealPulse;
    logic [7:0]    r_count;

    always_comb begin
        w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_num      = (w_lfsrNext[4:2] % 3'd5) + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // WAIT spends DEAL_PERIOD-1 cycles, so flips land exactly DEAL_PERIOD apart.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (start) w_stateNext = S_DEAL;
            S_DEAL:  w_stateNext = bell_hit ? S_HOLD : S_WAIT;
            S_WAIT: begin
                if (bell_hit) begin
                    w_stateNext = S_HOLD;
                end else if (r_timer == TIMER_LAST) begin
                    w_stateNext = S_DEAL;
                end
            end
            S_HOLD:  if (bell_done) w_stateNext = S_CLEAR;
            S_CLEAR: w_stateNext = S_DEAL;
            default: w_stateNext = S_IDLE;
        endcase
        if (stop) begin
            w_stateNext = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= SEED_EFF;
            r_timer     <= '0;
            r_turn      <= 1'b0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_cardValid <= 1'b0;
            r_dealPulse <= 1'b0;
            r_count     <= '0;
        end else if (stop) begin
            // The LFSR is deliberately kept so the next game draws fresh cards.
            r_timer     <= '0;
            r_turn      <= 1'b0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_cardValid <= 1'b0;
            r_dealPulse <= 1'b0;
            r_count     <= '0;
        end else begin
            r_dealPulse <= 1'b0;
            case (r_state)
                S_DEAL: begin
                    r_lfsr      <= w_lfsrNext;
                    r_timer     <= '0;
                    r_dealPulse <= 1'b1;
                    r_turn      <= ~r_turn;
                    if (r_turn) begin
                        r_c2        <= w_lfsrNext[1:0];
                        r_n2        <= w_num;
                        r_cardValid <= 1'b1;
                    end else begin
                        r_c1 <= w_lfsrNext[1:0];
                        r_n1 <= w_num;
                    end
                    if (r_count != 8'hFF) begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_WAIT: r_timer <= r_timer + TW'(1);
                S_CLEAR: begin
                    r_turn      <= 1'b0;
                    r_c1        <= '0;
                    r_c2        <= '0;
                    r_n1        <= '0;
                    r_n2        <= '0;
                    r_cardValid <= 1'b0;
                    r_count     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign c1         = r_c1;
    assign c2         = r_c2;
    assign n1         = r_n1;
    assign n2         = r_n2;
    assign card_valid = r_cardValid;
    assign deal_pulse = r_dealPulse;
    assign count      = r_count;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: expected flips are queued by the stimulus and
// checked by a monitor whenever deal_pulse is seen; a second instance covers saturation.
module tb_card_dealer;

    typedef struct packed {
        logic [1:0] c1;
        logic [2:0] n1;
        logic [1:0] c2;
        logic [2:0] n2;
        logic       v;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, bellHit, bellDone, start2;
    logic [1:0] c1, c2, c1b, c2b;
    logic [2:0] n1, n2, n1b, n2b;
    logic       cardValid, dealPulse, cardValidB, dealPulseB;
    logic [7:0] count, countB;

    exp_t expQ[$];
    int   nVectors = 0;
    int   nMiscompares = 0;
    int   cyc = 0;
    int   k2 = 0;
    int   lastCyc2 = 0;
    int   w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    card_dealer #(.DEAL_PERIOD(4), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .bell_hit(bellHit), .bell_done(bellDone),
        .c1(c1), .c2(c2), .n1(n1), .n2(n2),
        .card_valid(cardValid), .deal_pulse(dealPulse), .count(count)
    );

    card_dealer #(.DEAL_PERIOD(2), .SEED(16'hACE1)) dutSat (
        .clk(clk), .rst(rst), .start(start2), .stop(1'b0),
        .bell_hit(1'b0), .bell_done(1'b0),
        .c1(c1b), .c2(c2b), .n1(n1b), .n2(n2b),
        .card_valid(cardValidB), .deal_pulse(dealPulseB), .count(countB)
    );

    function automatic exp_t mk(int a, int b, int c, int d, int v, int cnt);
        exp_t e;
        e.c1 = 2'(a); e.n1 = 3'(b); e.c2 = 2'(c); e.n2 = 3'(d);
        e.v = 1'(v); e.cnt = 8'(cnt);
        return e;
    endfunction

    function automatic exp_t actual();
        return {c1, n1, c2, n2, cardValid, count};
    endfunction

    function automatic void report(string name, exp_t got, exp_t want);
        $display("[TB] FAIL %s: got c1=%0d n1=%0d c2=%0d n2=%0d valid=%0d count=%0d, required c1=%0d n1=%0d c2=%0d n2=%0d valid=%0d count=%0d",
                 name, got.c1, got.n1, got.c2, got.n2, got.v, got.cnt,
                 want.c1, want.n1, want.c2, want.n2, want.v, want.cnt);
    endfunction

    // Scoreboard monitor: every flip on the main instance must match a queued entry.
    always @(negedge clk) begin
        if (dealPulse === 1'b1) begin
            nVectors++;
            if (expQ.size() == 0) begin
                nMiscompares++;
                $display("[TB] FAIL unexpected_flip: deal_pulse seen at cycle %0d with no flip expected", cyc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (actual() !== e) begin
                    nMiscompares++;
                    report("flip", actual(), e);
                end
            end
        end
    end

    // Saturation monitor: count follows the flip number up to 255, flips every 2 cycles.
    always @(negedge clk) begin
        if (dealPulseB === 1'b1) begin
            k2++;
            nVectors++;
            if (int'(countB) != ((k2 > 255) ? 255 : k2)) begin
                nMiscompares++;
                $display("[TB] FAIL sat_count: flip %0d got count=%0d required %0d",
                         k2, countB, (k2 > 255) ? 255 : k2);
            end
            if (k2 > 1) begin
                nVectors++;
                if (cyc - lastCyc2 != 2) begin
                    nMiscompares++;
                    $display("[TB] FAIL sat_cadence: flip %0d got gap %0d required 2", k2, cyc - lastCyc2);
                end
            end
            lastCyc2 = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st, input logic bh, input logic bd);
        start = s; stop = st; bellHit = bh; bellDone = bd;
        tick(1);
        start = 1'b0; stop = 1'b0; bellHit = 1'b0; bellDone = 1'b0;
    endtask

    task automatic checkOutput(input string name, input exp_t want, input logic wantPulse);
        nVectors++;
        if (actual() !== want || dealPulse !== wantPulse) begin
            nMiscompares++;
            report(name, actual(), want);
            $display("[TB] FAIL %s: deal_pulse got %0d required %0d", name, dealPulse, wantPulse);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        nVectors++;
        if (got != want) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic waitPulse(input int limit, output int waited);
        waited = 0;
        do begin
            tick(1);
            waited++;
        end while (dealPulse !== 1'b1 && waited < limit);
        if (dealPulse !== 1'b1) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL flip_timeout: no deal_pulse within %0d cycles", limit);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; bellHit = 1'b0; bellDone = 1'b0; start2 = 1'b0;
        tick(2);
        rst = 1'b0;
        checkOutput("reset", mk(0, 0, 0, 0, 0, 0), 1'b0);
        tick(2);

        // First three flips from seed ACE1: 59C3, B387, 670F.
        expQ.push_back(mk(3, 1, 0, 0, 0, 1));
        expQ.push_back(mk(3, 1, 3, 2, 1, 2));
        expQ.push_back(mk(3, 4, 3, 2, 1, 3));
        applyStimulus(1, 0, 0, 0);
        waitPulse(10, w); checkInt("start_latency", w, 1);
        waitPulse(10, w); checkInt("flip_spacing", w, 4);
        waitPulse(10, w);

        // Bell one cycle into WAIT: table freezes until bell_done.
        applyStimulus(0, 0, 1, 0);
        tick(20);
        checkOutput("hold_frozen", mk(3, 4, 3, 2, 1, 3), 1'b0);
        expQ.push_back(mk(2, 3, 0, 0, 0, 1));
        applyStimulus(0, 0, 0, 1);
        tick(1); checkOutput("cleared", mk(0, 0, 0, 0, 0, 0), 1'b0);
        tick(1); checkOutput("flip_after_clear", mk(2, 3, 0, 0, 0, 1), 1'b1);
        expQ.push_back(mk(2, 3, 0, 3, 1, 2));
        waitPulse(10, w); checkInt("spacing_after_clear", w, 4);

        // bell_hit and bell_done together in HOLD: done wins, hit is dropped.
        applyStimulus(0, 0, 1, 0);
        expQ.push_back(mk(1, 2, 0, 0, 0, 1));
        applyStimulus(0, 0, 1, 1);
        tick(1); checkOutput("simul_cleared", mk(0, 0, 0, 0, 0, 0), 1'b0);
        tick(1); checkOutput("simul_flip", mk(1, 2, 0, 0, 0, 1), 1'b1);
        expQ.push_back(mk(1, 2, 2, 5, 1, 2));
        waitPulse(10, w); checkInt("dropped_bell_spacing", w, 4);

        // stop in WAIT (start alongside is ignored); restart continues the LFSR.
        applyStimulus(1, 1, 0, 0);
        checkOutput("stop_clears", mk(0, 0, 0, 0, 0, 0), 1'b0);
        tick(6);
        checkOutput("idle_after_stop", mk(0, 0, 0, 0, 0, 0), 1'b0);
        expQ.push_back(mk(0, 2, 0, 0, 0, 1));
        applyStimulus(1, 0, 0, 0);
        waitPulse(10, w); checkInt("restart_latency", w, 1);

        // Reset during HOLD: everything returns to reset values and the seed reloads.
        applyStimulus(0, 0, 1, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("reset_mid_hold", mk(0, 0, 0, 0, 0, 0), 1'b0);
        applyStimulus(0, 0, 0, 1);
        tick(3);
        applyStimulus(0, 0, 0, 1);
        tick(3);
        checkOutput("bell_done_ignored", mk(0, 0, 0, 0, 0, 0), 1'b0);
        expQ.push_back(mk(3, 1, 0, 0, 0, 1));
        expQ.push_back(mk(3, 1, 3, 2, 1, 2));
        applyStimulus(1, 0, 0, 0);
        waitPulse(10, w); checkInt("reseed_latency", w, 1);
        waitPulse(10, w);
        applyStimulus(0, 1, 0, 0);
        tick(2);
        checkInt("scoreboard_drained", expQ.size(), 0);

        // Saturation on the fast instance.
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(604);
        checkInt("sat_final_count", int'(countB), 255);
        checkInt("sat_enough_flips", (k2 >= 300) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
